// File: rtl/add_seq_pkg.sv
// Shared types and constants for the two-requester multi-word sequential adder.
package add_seq_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned NREQ          = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Side-band flags travelling with each result word.
  typedef struct packed {
    logic last;
    logic carry;
    logic err;
    logic id;
  } sum_flag_t;

endpackage

// File: rtl/add32_cin.sv
// Combinational word adder with carry-in and carry-out.
module add32_cin
  import add_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);

endmodule

// File: rtl/add_seq_arbiter.sv
// Round-robin arbiter feeding one shared adder with multi-word operations,
// carry chained word to word and results emitted least-significant first.
module add_seq_arbiter
  import add_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEFAULT,
  parameter int unsigned MAX_WORDS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_last,
  output logic                  sum_valid,
  input  logic                  sum_ready,
  output logic [WIDTH-1:0]      sum_data,
  output logic                  sum_last,
  output logic                  sum_carry,
  output logic                  sum_err,
  output logic                  sum_id,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_q, rr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sum_valid_q, sum_valid_d;
  logic [WIDTH-1:0] sum_data_q, sum_data_d;
  sum_flag_t        sum_flag_q, sum_flag_d;

  logic             grant_c;
  logic             out_free_c;
  logic             accept_c;
  logic             at_limit_c;
  logic             final_c;
  logic [WIDTH-1:0] add_a_c, add_b_c, add_sum_c;
  logic             add_cout_c;

  // Owner operand select and shared adder.
  assign add_a_c = owner_q ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign add_b_c = owner_q ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

  add32_cin #(.WIDTH(WIDTH)) u_add (
    .a    (add_a_c),
    .b    (add_b_c),
    .cin  (carry_q),
    .sum  (add_sum_c),
    .cout (add_cout_c)
  );

  // Both valid: rr_q names the favoured requester; otherwise the lone one.
  assign grant_c    = (req_valid[0] && req_valid[1]) ? rr_q : !req_valid[0];
  assign out_free_c = !sum_valid_q || sum_ready;
  assign accept_c   = (state_q == ST_RUN) && req_valid[owner_q] && out_free_c;
  assign at_limit_c = (cnt_q == CNT_W'(MAX_WORDS - 1));
  assign final_c    = req_last[owner_q] || at_limit_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      rr_q        <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_valid_q <= 1'b0;
      sum_data_q  <= '0;
      sum_flag_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_valid_q <= sum_valid_d;
      sum_data_q  <= sum_data_d;
      sum_flag_q  <= sum_flag_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (|req_valid)          state_d = ST_RUN;
      ST_RUN:  if (accept_c && final_c) state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Datapath updates and handshake.
  always_comb begin
    owner_d     = owner_q;
    rr_d        = rr_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_valid_d = sum_valid_q;
    sum_data_d  = sum_data_q;
    sum_flag_d  = sum_flag_q;
    req_ready   = '0;

    if (sum_valid_q && sum_ready) sum_valid_d = 1'b0;

    if (state_q == ST_IDLE) begin
      if (|req_valid) begin
        owner_d = grant_c;
        rr_d    = !grant_c;
        carry_d = 1'b0;
        cnt_d   = '0;
      end
    end else begin
      req_ready[owner_q] = out_free_c;
      if (accept_c) begin
        cnt_d            = cnt_q + CNT_W'(1);
        carry_d          = add_cout_c;
        sum_valid_d      = 1'b1;
        sum_data_d       = add_sum_c;
        sum_flag_d.last  = final_c;
        sum_flag_d.carry = final_c && add_cout_c;
        sum_flag_d.err   = at_limit_c && !req_last[owner_q];
        sum_flag_d.id    = owner_q;
      end
    end
  end

  assign sum_valid = sum_valid_q;
  assign sum_data  = sum_data_q;
  assign sum_last  = sum_flag_q.last;
  assign sum_carry = sum_flag_q.carry;
  assign sum_err   = sum_flag_q.err;
  assign sum_id    = sum_flag_q.id;
  assign busy      = (state_q != ST_IDLE) || sum_valid_q;

endmodule

// File: tb/tb_add_seq_arbiter.sv
// Directed self-checking bench for add_seq_arbiter (WIDTH=32, MAX_WORDS=8).
module tb_add_seq_arbiter;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        last;
  } word_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  req_last;
  logic        sum_valid;
  logic        sum_ready;
  logic [31:0] sum_data;
  logic        sum_last;
  logic        sum_carry;
  logic        sum_err;
  logic        sum_id;
  logic        busy;

  word_t       q0[$];
  word_t       q1[$];
  logic [35:0] out_q[$];
  logic [1:0]  hs;
  int          n_cmp;
  int          n_err;

  add_seq_arbiter #(.WIDTH(32), .MAX_WORDS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_last  (req_last),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_data  (sum_data),
    .sum_last  (sum_last),
    .sum_carry (sum_carry),
    .sum_err   (sum_err),
    .sum_id    (sum_id),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic word_t wd(logic [31:0] a, logic [31:0] b, logic last);
    word_t w;
    w.a = a;
    w.b = b;
    w.last = last;
    return w;
  endfunction

  // Result entry layout: {id, err, carry, last, data}.
  function automatic logic [35:0] ent(logic id, logic err, logic carry, logic last,
                                      logic [31:0] data);
    return {id, err, carry, last, data};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(string tag, logic [35:0] exp);
    logic [63:0] obs;
    if (out_q.size() == 0) obs = 64'hFFFF_FFFF_FFFF_FFFF;
    else obs = 64'(out_q.pop_front());
    chk(tag, obs, 64'(exp));
  endtask

  task automatic wait_out(string tag, int n, int budget);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(out_q.size() >= n), 64'd1);
  endtask

  task automatic wait_sum_valid(string tag);
    logic seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (sum_valid) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    out_q.delete();
    rst_n = 1'b1;
  endtask

  // Requester drivers: present queue heads, pop on a handshake seen before the edge.
  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (hs[0] && q0.size() > 0) void'(q0.pop_front());
      if (hs[1] && q1.size() > 0) void'(q1.pop_front());
      req_valid[0] = (q0.size() > 0);
      req_valid[1] = (q1.size() > 0);
      req_a[31:0]  = (q0.size() > 0) ? q0[0].a : 32'h0;
      req_b[31:0]  = (q0.size() > 0) ? q0[0].b : 32'h0;
      req_last[0]  = (q0.size() > 0) ? q0[0].last : 1'b0;
      req_a[63:32] = (q1.size() > 0) ? q1[0].a : 32'h0;
      req_b[63:32] = (q1.size() > 0) ? q1[0].b : 32'h0;
      req_last[1]  = (q1.size() > 0) ? q1[0].last : 1'b0;
    end
  end

  // Result monitor: log every word the consumer takes.
  always @(negedge clk) begin
    if (rst_n && sum_valid && sum_ready)
      out_q.push_back({sum_id, sum_err, sum_carry, sum_last, sum_data});
  end

  initial begin
    logic found;
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    sum_ready = 1'b1;

    #3;
    chk("reset_outputs",
        64'({sum_valid, sum_data, sum_last, sum_carry, sum_err, sum_id, req_ready, busy}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single-word add with carry out, registered one cycle after acceptance.
    q0.push_back(wd(32'hFFFF_FFFF, 32'h1, 1'b1));
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (req_valid[0] && req_ready[0]) found = 1'b1;
    end
    chk("single_accept", 64'(found), 64'd1);
    @(negedge clk);
    chk("single_next_cycle",
        64'({sum_valid, sum_id, sum_err, sum_carry, sum_last, sum_data}),
        64'({1'b1, ent(1'b0, 1'b0, 1'b1, 1'b1, 32'h0)}));
    repeat (2) @(negedge clk);
    chk("single_idle_busy", 64'(busy), 64'd0);
    out_q.delete();

    // Requester 1, four words with full carry ripple.
    q1.push_back(wd(32'hFFFF_FFFF, 32'h1, 1'b0));
    q1.push_back(wd(32'hFFFF_FFFF, 32'h0, 1'b0));
    q1.push_back(wd(32'hFFFF_FFFF, 32'h0, 1'b0));
    q1.push_back(wd(32'hFFFF_FFFF, 32'h0, 1'b1));
    wait_out("four_wait", 4, 40);
    chk_out("four_w1", ent(1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    chk_out("four_w2", ent(1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    chk_out("four_w3", ent(1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    chk_out("four_w4", ent(1'b1, 1'b0, 1'b1, 1'b1, 32'h0));

    // Contention after reset: requester 0 first, no interleaving.
    do_reset();
    q0.push_back(wd(32'd1, 32'd2, 1'b0));
    q0.push_back(wd(32'd3, 32'd4, 1'b1));
    q1.push_back(wd(32'd10, 32'd20, 1'b0));
    q1.push_back(wd(32'd30, 32'd40, 1'b1));
    wait_out("arb_wait", 4, 40);
    chk_out("arb_r0_w1", ent(1'b0, 1'b0, 1'b0, 1'b0, 32'd3));
    chk_out("arb_r0_w2", ent(1'b0, 1'b0, 1'b0, 1'b1, 32'd7));
    chk_out("arb_r1_w1", ent(1'b1, 1'b0, 1'b0, 1'b0, 32'd30));
    chk_out("arb_r1_w2", ent(1'b1, 1'b0, 1'b0, 1'b1, 32'd70));

    // Consumer back-pressure for three cycles mid-operation.
    for (int i = 1; i <= 4; i++)
      q0.push_back(wd(32'(i), 32'h100, i == 4));
    wait_sum_valid("stall_first_valid");
    chk("stall_first_data", 64'(sum_data), 64'h101);
    @(posedge clk);
    #1;
    sum_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold", 64'({sum_valid, req_ready, sum_data}), 64'({1'b1, 2'b00, 32'h102}));
    end
    @(posedge clk);
    #1;
    sum_ready = 1'b1;
    wait_out("stall_wait", 4, 40);
    repeat (5) @(negedge clk);
    chk("stall_count", 64'(out_q.size()), 64'd4);
    for (int i = 1; i <= 4; i++)
      chk_out("stall_word", ent(1'b0, 1'b0, 1'b0, i == 4, 32'h100 + 32'(i)));

    // Nine words with no last: the eighth ends in overrun, the ninth restarts.
    q0.push_back(wd(32'hFFFF_FFFF, 32'h1, 1'b0));
    for (int i = 2; i <= 8; i++)
      q0.push_back(wd(32'hFFFF_FFFF, 32'h0, 1'b0));
    q0.push_back(wd(32'hFFFF_FFFF, 32'h0, 1'b1));
    wait_out("ovr_wait", 9, 80);
    for (int i = 1; i <= 7; i++)
      chk_out("ovr_mid", ent(1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    chk_out("ovr_w8", ent(1'b0, 1'b1, 1'b1, 1'b1, 32'h0));
    chk_out("ovr_w9", ent(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF));

    // Reset in the middle of a four-word operation.
    q0.push_back(wd(32'hFFFF_FFFF, 32'h1, 1'b0));
    q0.push_back(wd(32'hFFFF_FFFF, 32'h0, 1'b0));
    q0.push_back(wd(32'hFFFF_FFFF, 32'h0, 1'b0));
    q0.push_back(wd(32'hFFFF_FFFF, 32'h0, 1'b1));
    wait_sum_valid("rst_mid_first_valid");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("rst_mid_outputs",
        64'({sum_valid, sum_data, sum_last, sum_carry, sum_err, sum_id, req_ready, busy}), 64'd0);
    repeat (2) @(negedge clk);
    out_q.delete();
    rst_n = 1'b1;
    q0.push_back(wd(32'hFFFF_FFFF, 32'h0, 1'b1));
    q1.push_back(wd(32'h1, 32'h1, 1'b1));
    wait_out("rst_after_wait", 2, 30);
    chk_out("rst_after_r0", ent(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF));
    chk_out("rst_after_r1", ent(1'b1, 1'b0, 1'b0, 1'b1, 32'h2));
    repeat (5) @(negedge clk);
    chk("rst_no_leftover", 64'(out_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
